miner_work_sched: RTL and testbench

- Sequences the double-SHA-256 hasher pair for one job at a time.
- Accepts jobs (midstate, 96-bit data tail, nonce range) over a valid/ready handshake, with a one-deep queue for the next job.
- Drives the hasher's sub-round count, feedback, state and data inputs, and sweeps the nonce range.
- Converts the comparator's hit pulse into a golden nonce and buffers results in a 4-entry FIFO for the host-side readout.

---
 rtl/miner_work_sched.sv | 190 +++++++++++++++++++
 tb/tb_miner_work_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_work_sched.sv
// Job sequencer for the double-SHA-256 hasher pair: one-deep job queue,
// nonce sweep with sub-round counting, drain tail, golden-nonce FIFO.
module miner_work_sched #(
  parameter int unsigned LOOP_LOG2  = 0,
  parameter int unsigned HIT_OFFSET = 128,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         hash_clk,
  input  logic         reset,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  work_nonce_start,
  input  logic [31:0]  work_nonce_end,
  input  logic         abort,
  output logic [255:0] hs_state,
  output logic [127:0] hs_data,
  output logic [5:0]   hs_cnt,
  output logic         hs_feedback,
  input  logic         hit_in,
  output logic         gn_valid,
  input  logic         gn_ready,
  output logic [31:0]  gn_nonce,
  output logic         gn_overflow,
  output logic         busy,
  output logic         job_done
);

  localparam logic [5:0]  LOOP_MASK = 6'((1 << LOOP_LOG2) - 1);
  localparam logic [31:0] HO_C      = 32'(HIT_OFFSET);
  localparam logic [31:0] HO_LAST   = 32'(HIT_OFFSET - 1);
  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C   = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  logic          r_sh_valid;
  logic [255:0]  r_sh_mid;
  logic [95:0]   r_sh_data;
  logic [31:0]   r_sh_start;
  logic [31:0]   r_sh_end;
  logic [255:0]  r_act_mid;
  logic [95:0]   r_act_data;
  logic [31:0]   r_act_start;
  logic [31:0]   r_act_end;
  logic [31:0]   r_act_span;
  logic [31:0]   r_nonce;
  logic [5:0]    r_cnt;
  logic          r_fb;
  logic [31:0]   r_drain;
  logic          r_job_done;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_count;
  logic          r_ovf;

  logic [5:0]    w_cnt_next;
  logic          w_slot_end;
  logic          w_active;
  logic [31:0]   w_cand;
  logic          w_push;
  logic          w_push_ok;
  logic          w_pop;
  logic          w_full;
  logic          w_load;
  logic          w_accept;

  // Next sub-round, hit qualification and FIFO/queue handshakes
  always_comb begin
    w_cnt_next = (r_cnt + 6'd1) & LOOP_MASK;
    w_slot_end = (w_cnt_next == '0);
    w_active   = (r_state != S_IDLE);
    w_cand     = r_nonce - HO_C;
    w_push     = w_active && hit_in && ((w_cand - r_act_start) <= r_act_span);
    w_full     = (r_count == DEPTH_C);
    w_pop      = gn_ready && (r_count != '0);
    w_push_ok  = w_push && (!w_full || w_pop);
    w_load     = (r_state == S_IDLE) && r_sh_valid;
    w_accept   = work_valid && !r_sh_valid;
  end

  // Job queue, sweep FSM and hasher input registers
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sh_valid  <= 1'b0;
      r_sh_mid    <= '0;
      r_sh_data   <= '0;
      r_sh_start  <= '0;
      r_sh_end    <= '0;
      r_act_mid   <= '0;
      r_act_data  <= '0;
      r_act_start <= '0;
      r_act_end   <= '0;
      r_act_span  <= '0;
      r_nonce     <= '0;
      r_cnt       <= '0;
      r_fb        <= 1'b0;
      r_drain     <= '0;
      r_job_done  <= 1'b0;
    end else begin
      r_job_done <= 1'b0;
      // accept needs an empty shadow, load needs a full one: never both
      if (w_accept) begin
        r_sh_valid <= 1'b1;
        r_sh_mid   <= work_midstate;
        r_sh_data  <= work_data;
        r_sh_start <= work_nonce_start;
        r_sh_end   <= work_nonce_end;
      end
      case (r_state)
        S_IDLE: begin
          if (r_sh_valid) begin
            r_act_mid   <= r_sh_mid;
            r_act_data  <= r_sh_data;
            r_act_start <= r_sh_start;
            r_act_end   <= r_sh_end;
            r_act_span  <= r_sh_end - r_sh_start;
            r_nonce     <= r_sh_start;
            r_cnt       <= '0;
            r_fb        <= 1'b0;
            r_sh_valid  <= 1'b0;
            r_state     <= S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_next;
            r_fb  <= !w_slot_end;
            if (w_slot_end) begin
              if (r_state == S_RUN) begin
                r_nonce <= r_nonce + 32'd1;
                if (r_nonce == r_act_end) begin
                  r_state <= S_DRAIN;
                  r_drain <= '0;
                end
              end else if (r_drain == HO_LAST) begin
                r_state    <= S_IDLE;
                r_job_done <= 1'b1;
              end else begin
                r_nonce <= r_nonce + 32'd1;
                r_drain <= r_drain + 32'd1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Golden-nonce FIFO with sticky overflow, cleared when a job loads
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wp] <= w_cand;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      if (w_load)                        r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign work_ready  = !r_sh_valid;
  assign hs_state    = r_act_mid;
  assign hs_data     = {r_nonce, r_act_data};
  assign hs_cnt      = r_cnt;
  assign hs_feedback = r_fb;
  assign gn_valid    = (r_count != '0);
  assign gn_nonce    = r_mem[r_rp];
  assign gn_overflow = r_ovf;
  assign busy        = (r_state != S_IDLE);
  assign job_done    = r_job_done;

endmodule

// File: tb/tb_miner_work_sched.sv
// Bench for miner_work_sched: two instances (LOOP=1 and LOOP=4) driven by
// shared stimulus and checked every cycle against a job-timeline model.
module tb_miner_work_sched;

  localparam int unsigned HO = 128;

  logic         hash_clk;
  logic         reset;
  logic [1:0]   wv;
  logic [255:0] w_mid;
  logic [95:0]  w_data;
  logic [31:0]  w_start;
  logic [31:0]  w_end;
  logic         abort;
  logic         hit_in;
  logic         gn_ready;

  logic         work_ready_o  [2];
  logic [255:0] hs_state_o    [2];
  logic [127:0] hs_data_o     [2];
  logic [5:0]   hs_cnt_o      [2];
  logic         hs_feedback_o [2];
  logic         gn_valid_o    [2];
  logic [31:0]  gn_nonce_o    [2];
  logic         gn_overflow_o [2];
  logic         busy_o        [2];
  logic         job_done_o    [2];

  miner_work_sched #(.LOOP_LOG2(0), .HIT_OFFSET(HO), .FIFO_DEPTH(4)) u_dut0 (
    .hash_clk(hash_clk), .reset(reset), .work_valid(wv[0]), .work_ready(work_ready_o[0]),
    .work_midstate(w_mid), .work_data(w_data), .work_nonce_start(w_start),
    .work_nonce_end(w_end), .abort(abort), .hs_state(hs_state_o[0]), .hs_data(hs_data_o[0]),
    .hs_cnt(hs_cnt_o[0]), .hs_feedback(hs_feedback_o[0]), .hit_in(hit_in),
    .gn_valid(gn_valid_o[0]), .gn_ready(gn_ready), .gn_nonce(gn_nonce_o[0]),
    .gn_overflow(gn_overflow_o[0]), .busy(busy_o[0]), .job_done(job_done_o[0]));

  miner_work_sched #(.LOOP_LOG2(2), .HIT_OFFSET(HO), .FIFO_DEPTH(4)) u_dut1 (
    .hash_clk(hash_clk), .reset(reset), .work_valid(wv[1]), .work_ready(work_ready_o[1]),
    .work_midstate(w_mid), .work_data(w_data), .work_nonce_start(w_start),
    .work_nonce_end(w_end), .abort(abort), .hs_state(hs_state_o[1]), .hs_data(hs_data_o[1]),
    .hs_cnt(hs_cnt_o[1]), .hs_feedback(hs_feedback_o[1]), .hit_in(hit_in),
    .gn_valid(gn_valid_o[1]), .gn_ready(gn_ready), .gn_nonce(gn_nonce_o[1]),
    .gn_overflow(gn_overflow_o[1]), .busy(busy_o[1]), .job_done(job_done_o[1]));

  initial begin
    hash_clk = 1'b0;
    forever #5 hash_clk = ~hash_clk;
  end

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a job is a timeline of (span+1+HO)*LOOP cycles; the
  // issued nonce is start + k/LOOP and the sub-round is k%LOOP.
  bit           m_busy  [2];
  int unsigned  m_k     [2];
  bit           m_done  [2];
  bit           m_acc   [2];
  bit           m_sh_v  [2];
  logic [255:0] m_sh_mid   [2];
  logic [95:0]  m_sh_data  [2];
  logic [31:0]  m_sh_start [2];
  logic [31:0]  m_sh_end   [2];
  logic [255:0] m_mid   [2];
  logic [95:0]  m_data  [2];
  logic [31:0]  m_start [2];
  logic [31:0]  m_span  [2];
  logic [31:0]  m_fifo  [2][4];
  int unsigned  m_cnt   [2];
  bit           m_ovf   [2];

  function automatic int unsigned loop_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] issued(input int d);
    return m_start[d] + 32'(m_k[d] / loop_of(d));
  endfunction

  task automatic model_reset(input int d);
    m_busy[d] = 0; m_k[d] = 0; m_done[d] = 0; m_acc[d] = 0;
    m_sh_v[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0;
  endtask

  task automatic model_step(input int d);
    logic [31:0] cand;
    longint      total;
    if (reset) begin
      model_reset(d);
      return;
    end
    m_acc[d] = wv[d] && !m_sh_v[d];
    if (gn_ready && m_cnt[d] != 0) begin
      for (int unsigned i = 0; i < 3; i++) m_fifo[d][i] = m_fifo[d][i+1];
      m_cnt[d]--;
    end
    if (m_busy[d] && hit_in) begin
      cand = issued(d) - HO;
      if ((cand - m_start[d]) <= m_span[d]) begin
        if (m_cnt[d] < 4) begin
          m_fifo[d][m_cnt[d]] = cand;
          m_cnt[d]++;
        end else begin
          m_ovf[d] = 1;
        end
      end
    end
    m_done[d] = 0;
    if (m_busy[d]) begin
      if (abort) begin
        m_busy[d] = 0;
      end else begin
        m_k[d]++;
        total = (longint'(m_span[d]) + 1 + HO) * loop_of(d);
        if (longint'(m_k[d]) == total) begin
          m_busy[d] = 0;
          m_done[d] = 1;
        end
      end
    end else if (m_sh_v[d]) begin
      m_mid[d]   = m_sh_mid[d];
      m_data[d]  = m_sh_data[d];
      m_start[d] = m_sh_start[d];
      m_span[d]  = m_sh_end[d] - m_sh_start[d];
      m_sh_v[d]  = 0;
      m_busy[d]  = 1;
      m_k[d]     = 0;
      m_ovf[d]   = 0;
    end
    if (m_acc[d]) begin
      m_sh_v[d]     = 1;
      m_sh_mid[d]   = w_mid;
      m_sh_data[d]  = w_data;
      m_sh_start[d] = w_start;
      m_sh_end[d]   = w_end;
    end
  endtask

  task automatic compare(input int d);
    check($sformatf("busy%0d", d), 256'(busy_o[d]), 256'(m_busy[d]));
    check($sformatf("work_ready%0d", d), 256'(work_ready_o[d]), 256'(!m_sh_v[d]));
    check($sformatf("job_done%0d", d), 256'(job_done_o[d]), 256'(m_done[d]));
    check($sformatf("gn_valid%0d", d), 256'(gn_valid_o[d]), 256'(m_cnt[d] != 0));
    check($sformatf("gn_overflow%0d", d), 256'(gn_overflow_o[d]), 256'(m_ovf[d]));
    if (m_cnt[d] != 0)
      check($sformatf("gn_nonce%0d", d), 256'(gn_nonce_o[d]), 256'(m_fifo[d][0]));
    if (m_busy[d]) begin
      check($sformatf("hs_nonce%0d", d), 256'(hs_data_o[d][127:96]), 256'(issued(d)));
      check($sformatf("hs_tail%0d", d), 256'(hs_data_o[d][95:0]), 256'(m_data[d]));
      check($sformatf("hs_state%0d", d), hs_state_o[d], m_mid[d]);
      check($sformatf("hs_cnt%0d", d), 256'(hs_cnt_o[d]), 256'(m_k[d] % loop_of(d)));
      check($sformatf("hs_fb%0d", d), 256'(hs_feedback_o[d]), 256'((m_k[d] % loop_of(d)) != 0));
    end
  endtask

  task automatic check_reset_vals(input int d);
    check($sformatf("rst_busy%0d", d), 256'(busy_o[d]), 256'(0));
    check($sformatf("rst_work_ready%0d", d), 256'(work_ready_o[d]), 256'(1));
    check($sformatf("rst_job_done%0d", d), 256'(job_done_o[d]), 256'(0));
    check($sformatf("rst_gn_valid%0d", d), 256'(gn_valid_o[d]), 256'(0));
    check($sformatf("rst_gn_nonce%0d", d), 256'(gn_nonce_o[d]), 256'(0));
    check($sformatf("rst_gn_overflow%0d", d), 256'(gn_overflow_o[d]), 256'(0));
    check($sformatf("rst_hs_state%0d", d), hs_state_o[d], 256'(0));
    check($sformatf("rst_hs_data%0d", d), 256'(hs_data_o[d]), 256'(0));
    check($sformatf("rst_hs_cnt%0d", d), 256'(hs_cnt_o[d]), 256'(0));
    check($sformatf("rst_hs_fb%0d", d), 256'(hs_feedback_o[d]), 256'(0));
  endtask

  // Stimulus policy applied each cycle (0 = random hits, 1 = two targets, 2 = range)
  int unsigned p_hit, p_pop, p_abort, hit_mode;
  logic [31:0] tgt_a, tgt_b;

  task automatic drive_policy();
    gn_ready = ($urandom_range(99) < p_pop);
    abort    = ($urandom_range(999) < p_abort);
    case (hit_mode)
      0:       hit_in = ($urandom_range(99) < p_hit);
      1:       hit_in = m_busy[0] && (issued(0) == tgt_a || issued(0) == tgt_b);
      default: hit_in = m_busy[0] && ((issued(0) - tgt_a) <= (tgt_b - tgt_a));
    endcase
  endtask

  task automatic tick();
    @(posedge hash_clk);
    model_step(0);
    model_step(1);
    @(negedge hash_clk);
    compare(0);
    compare(1);
    for (int d = 0; d < 2; d++) if (m_acc[d]) wv[d] = 1'b0;
    drive_policy();
  endtask

  task automatic offer(input logic [31:0] s, input logic [31:0] e);
    int unsigned n = 0;
    w_start = s;
    w_end   = e;
    w_data  = {$urandom, $urandom, $urandom};
    for (int unsigned i = 0; i < 8; i++) w_mid[i*32 +: 32] = $urandom;
    wv = 2'b11;
    while (wv != 2'b00 && n < 5000) begin
      tick();
      n++;
    end
    check("offer_accept", 256'(wv), 256'(0));
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while ((m_busy[0] || m_busy[1] || m_sh_v[0] || m_sh_v[1]) && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", 256'({busy_o[1], busy_o[0]}), 256'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    int unsigned n;
    reset = 1'b1; wv = '0; abort = 1'b0; hit_in = 1'b0; gn_ready = 1'b0;
    w_mid = '0; w_data = '0; w_start = '0; w_end = '0;
    p_hit = 0; p_pop = 0; p_abort = 0; hit_mode = 0; tgt_a = '0; tgt_b = '0;
    model_reset(0);
    model_reset(1);
    tick();
    tick();
    check_reset_vals(0);
    check_reset_vals(1);
    reset = 1'b0;
    tick();

    // Basic sweep 0x100..0x103 with hits at issued 0x182 (in range) and 0x184 (out)
    hit_mode = 1; tgt_a = 32'h182; tgt_b = 32'h184;
    offer(32'h100, 32'h103);
    wait_idle(2000);
    check("hit_valid", 256'(gn_valid_o[0]), 256'(1));
    check("hit_nonce", 256'(gn_nonce_o[0]), 256'(32'h102));
    hit_mode = 0; p_hit = 0;
    gn_ready = 1'b1;
    tick();
    check("oor_discard", 256'(gn_valid_o[0]), 256'(0));

    // Overflow: five in-range hits with no pops, then drain in order
    hit_mode = 2; tgt_a = 32'h280; tgt_b = 32'h284; p_pop = 0;
    offer(32'h200, 32'h20F);
    wait_idle(4000);
    check("ovf_set", 256'(gn_overflow_o[0]), 256'(1));
    check("ovf_head", 256'(gn_nonce_o[0]), 256'(32'h200));
    hit_mode = 0; p_hit = 0; p_pop = 100;
    repeat (6) tick();
    p_pop = 0;
    offer(32'h300, 32'h300);
    repeat (3) tick();
    check("ovf_cleared", 256'(gn_overflow_o[0]), 256'(0));
    wait_idle(2000);

    // Wrap-around range with hits on the candidates 0xFFFFFFFF and 0
    hit_mode = 1; tgt_a = 32'h7F; tgt_b = 32'h80;
    offer(32'hFFFF_FFFE, 32'h0000_0001);
    wait_idle(2000);
    check("wrap_head", 256'(gn_nonce_o[0]), 256'(32'hFFFF_FFFF));
    hit_mode = 0; p_pop = 100;
    repeat (4) tick();
    p_pop = 0;

    // Second job queued during RUN, then abort mid-RUN lets it start
    offer(32'h400, 32'h40F);
    offer(32'h500, 32'h503);
    check("queue_ready", 256'(work_ready_o[0]), 256'(0));
    n = 0;
    while (!(m_busy[0] && m_k[0] >= 5) && n < 100) begin tick(); n++; end
    abort = 1'b1;
    tick();
    wait_idle(4000);

    // Reset asserted mid-DRAIN clears everything immediately
    p_hit = 20; p_pop = 0;
    offer(32'h600, 32'h601);
    n = 0;
    while (!(m_busy[0] && m_k[0] >= 52) && n < 200) begin tick(); n++; end
    wv = '0;
    reset = 1'b1;
    #1;
    check_reset_vals(0);
    check_reset_vals(1);
    model_reset(0);
    model_reset(1);
    tick();
    tick();
    reset = 1'b0;
    p_hit = 0;
    repeat (3) tick();

    // Randomized jobs with random hits, pops and occasional aborts
    p_hit = 25; p_pop = 30; p_abort = 2; hit_mode = 0;
    for (int unsigned j = 0; j < 25; j++) begin
      s = ($urandom_range(3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(4))) : 32'($urandom);
      offer(s, s + 32'($urandom_range(6)));
      if (j % 5 == 4) wait_idle(6000);
    end
    p_abort = 0; p_hit = 0;
    wait_idle(6000);
    p_pop = 100;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
